jtpopeye_rstcen: RTL and testbench

Reset and clock-enable generator that sits directly downstream of the Popeye system PLL (50 MHz in, 40.317460 MHz out). It watches the PLL lock indication, holds the game in reset until lock has been stable for a programmable number of cycles, and then produces the single-cycle clock enables used by the video, CPU and PSG stages. All logic runs on the PLL output clock.

---
 rtl/jtpopeye_rstcen.sv | 161 ++++++++++++++++
 tb/tb_jtpopeye_rstcen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_rstcen.sv
// Reset and clock-enable generator for the Popeye core: keeps the game in reset
// until PLL lock has been stable for LOCK_CYCLES clocks, then emits clk/8, clk/10, clk/20 enables.
module jtpopeye_rstcen #(
  parameter int LOCK_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic rst_game,
  output logic cen_pxl,
  output logic cen_cpu,
  output logic cen_psg
);

  localparam int CW = $clog2(LOCK_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic          lock_meta_r;
  logic          lock_sync_r;
  logic          lock_s;
  state_t        state_r;
  state_t        state_nx_s;
  logic [CW-1:0] settle_cnt_r;
  logic [CW-1:0] settle_cnt_nx_s;
  logic [2:0]    div8_r;
  logic [2:0]    div8_nx_s;
  logic [3:0]    div10_r;
  logic [3:0]    div10_nx_s;
  logic [4:0]    div20_r;
  logic [4:0]    div20_nx_s;
  logic          run_now_s;
  logic          run_nx_s;
  logic          rst_game_r;
  logic          rst_game_nx_s;
  logic          cen_pxl_r;
  logic          cen_pxl_nx_s;
  logic          cen_cpu_r;
  logic          cen_cpu_nx_s;
  logic          cen_psg_r;
  logic          cen_psg_nx_s;

  assign lock_s = lock_sync_r;

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= pll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= WAIT_LOCK;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; lock loss takes priority over finishing the settle count
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx_s = SETTLE;
        end else begin
          state_nx_s = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nx_s = WAIT_LOCK;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = SETTLE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx_s = WAIT_LOCK;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = WAIT_LOCK;
      end
    endcase
  end

  // Counter and output next values; outputs follow the state being entered so
  // they change on the same edge as the state register
  always_comb begin
    run_now_s       = (state_r == RUN);
    run_nx_s        = (state_nx_s == RUN);
    settle_cnt_nx_s = '0;
    div8_nx_s       = 3'd0;
    div10_nx_s      = 4'd0;
    div20_nx_s      = 5'd0;
    if ((state_r == SETTLE) && (state_nx_s == SETTLE)) begin
      settle_cnt_nx_s = settle_cnt_r + CW'(1);
    end else begin
      settle_cnt_nx_s = '0;
    end
    // Dividers start from 0 on RUN entry and are cleared on the edge that leaves RUN
    if (run_now_s && run_nx_s) begin
      div8_nx_s  = (div8_r  == 3'd7)  ? 3'd0 : div8_r  + 3'd1;
      div10_nx_s = (div10_r == 4'd9)  ? 4'd0 : div10_r + 4'd1;
      div20_nx_s = (div20_r == 5'd19) ? 5'd0 : div20_r + 5'd1;
    end else begin
      div8_nx_s  = 3'd0;
      div10_nx_s = 4'd0;
      div20_nx_s = 5'd0;
    end
    rst_game_nx_s = !run_nx_s;
    cen_pxl_nx_s  = run_nx_s && (div8_nx_s  == 3'd7);
    cen_cpu_nx_s  = run_nx_s && (div10_nx_s == 4'd9);
    cen_psg_nx_s  = run_nx_s && (div20_nx_s == 5'd19);
  end

  // Counter and registered output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_r <= '0;
      div8_r       <= 3'd0;
      div10_r      <= 4'd0;
      div20_r      <= 5'd0;
      rst_game_r   <= 1'b1;
      cen_pxl_r    <= 1'b0;
      cen_cpu_r    <= 1'b0;
      cen_psg_r    <= 1'b0;
    end else begin
      settle_cnt_r <= settle_cnt_nx_s;
      div8_r       <= div8_nx_s;
      div10_r      <= div10_nx_s;
      div20_r      <= div20_nx_s;
      rst_game_r   <= rst_game_nx_s;
      cen_pxl_r    <= cen_pxl_nx_s;
      cen_cpu_r    <= cen_cpu_nx_s;
      cen_psg_r    <= cen_psg_nx_s;
    end
  end

  assign rst_game = rst_game_r;
  assign cen_pxl  = cen_pxl_r;
  assign cen_cpu  = cen_cpu_r;
  assign cen_psg  = cen_psg_r;

endmodule

// File: tb/tb_jtpopeye_rstcen.sv
// Self-checking bench for jtpopeye_rstcen: vector table, corner-case sequences
// and randomized lock traffic against a streak-based reference model.
module tb_jtpopeye_rstcen;

  localparam int LC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_locked = 1'b0;
  logic rst_game, cen_pxl, cen_cpu, cen_psg;

  int tests = 0;
  int fails = 0;

  // Model: s1/s2 are the last two lock samples, streak counts consecutive edges
  // that saw a synchronized lock of 1. RUN holds once streak exceeds LC.
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  int   streak = 0;

  always #5 clk = ~clk;

  jtpopeye_rstcen #(.LOCK_CYCLES(LC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .rst_game   (rst_game),
    .cen_pxl    (cen_pxl),
    .cen_cpu    (cen_cpu),
    .cen_psg    (cen_psg)
  );

  typedef struct {
    logic rst_n;
    logic pll;
    int   cycles;
    logic exp_rst;
  } vec_t;

  vec_t vt[9];

  function automatic void model_reset();
    s1 = 1'b0;
    s2 = 1'b0;
    streak = 0;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      streak = s2 ? streak + 1 : 0;
      s2 = s1;
      s1 = pll_locked;
    end
  endfunction

  function automatic logic m_rst();
    return (streak < LC + 1);
  endfunction

  function automatic logic m_cen(int per);
    return (streak >= LC + 1) && (((streak - LC - 1) % per) == per - 1);
  endfunction

  task automatic check(string name, logic got, logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_rst_game", rst_game, m_rst());
    check("model_cen_pxl", cen_pxl, m_cen(8));
    check("model_cen_cpu", cen_cpu, m_cen(10));
    check("model_cen_psg", cen_psg, m_cen(20));
  endtask

  task automatic check_in_reset(string name);
    check({name, "_rst_game"}, rst_game, 1'b1);
    check({name, "_cen_pxl"}, cen_pxl, 1'b0);
    check({name, "_cen_cpu"}, cen_cpu, 1'b0);
    check({name, "_cen_psg"}, cen_psg, 1'b0);
  endtask

  // Asserted between edges; outputs must clear without waiting for clk
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_in_reset("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Edges from the first lock sample up to and including the one dropping rst_game
  task automatic measure(string name);
    int n;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (!rst_game) break;
    end
    check_int(name, n, LC + 3);
  endtask

  initial begin
    int first_pxl, first_cpu, first_psg;
    int n_pxl, n_cpu, n_psg;
    int last_pxl, last_cpu, last_psg;
    logic fell;

    vt[0] = '{rst_n: 1'b0, pll: 1'b1, cycles: 3,  exp_rst: 1'b1};
    vt[1] = '{rst_n: 1'b1, pll: 1'b1, cycles: 18, exp_rst: 1'b1};
    vt[2] = '{rst_n: 1'b1, pll: 1'b1, cycles: 1,  exp_rst: 1'b0};
    vt[3] = '{rst_n: 1'b1, pll: 1'b1, cycles: 40, exp_rst: 1'b0};
    vt[4] = '{rst_n: 1'b1, pll: 1'b0, cycles: 2,  exp_rst: 1'b0};
    vt[5] = '{rst_n: 1'b1, pll: 1'b0, cycles: 1,  exp_rst: 1'b1};
    vt[6] = '{rst_n: 1'b1, pll: 1'b1, cycles: 18, exp_rst: 1'b1};
    vt[7] = '{rst_n: 1'b1, pll: 1'b1, cycles: 1,  exp_rst: 1'b0};
    vt[8] = '{rst_n: 1'b1, pll: 1'b1, cycles: 25, exp_rst: 1'b0};

    // Power-up with lock already asserted
    pll_locked = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_in_reset("powerup");

    for (int v = 0; v < 9; v++) begin
      rst_n = vt[v].rst_n;
      pll_locked = vt[v].pll;
      for (int c = 0; c < vt[v].cycles; c++) tick();
      check($sformatf("vec%0d_rst_game", v), rst_game, vt[v].exp_rst);
    end

    // Enable cadence over 200 cycles after E0
    pll_locked = 1'b1;
    do_reset();
    measure("powerup_release");
    first_pxl = -1; first_cpu = -1; first_psg = -1;
    n_pxl = 0; n_cpu = 0; n_psg = 0;
    last_pxl = 0; last_cpu = 0; last_psg = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (cen_pxl) begin
        if (n_pxl == 0) first_pxl = i; else check_int("pxl_period", i - last_pxl, 8);
        last_pxl = i; n_pxl++;
      end
      if (cen_cpu) begin
        if (n_cpu == 0) first_cpu = i; else check_int("cpu_period", i - last_cpu, 10);
        last_cpu = i; n_cpu++;
      end
      if (cen_psg) begin
        if (n_psg == 0) first_psg = i; else check_int("psg_period", i - last_psg, 20);
        last_psg = i; n_psg++;
        check("psg_with_cpu", cen_cpu, 1'b1);
      end
    end
    check_int("pxl_count", n_pxl, 25);
    check_int("cpu_count", n_cpu, 20);
    check_int("psg_count", n_psg, 10);
    check_int("pxl_first", first_pxl, 7);
    check_int("cpu_first", first_cpu, 9);
    check_int("psg_first", first_psg, 19);

    // Lock loss in RUN, then relock
    pll_locked = 1'b0;
    tick();
    tick();
    tick();
    check_in_reset("lockloss_d2");
    pll_locked = 1'b1;
    measure("relock_after_run");
    for (int i = 0; i < 25; i++) tick();

    // Glitch in SETTLE at counter 10
    do_reset();
    for (int i = 0; i < 13; i++) tick();
    pll_locked = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pll_locked = 1'b1;
    measure("relock_after_glitch");

    // Lock loss colliding with the last settle count
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    pll_locked = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rst_game) fell = 1'b1;
    end
    check("collision_never_run", fell, 1'b0);
    pll_locked = 1'b1;
    measure("relock_after_collision");

    // Async reset mid-run while cen_pxl is high
    for (int i = 0; i < 7; i++) tick();
    check("midrun_pxl_high", cen_pxl, 1'b1);
    do_reset();
    measure("relock_after_midrun_reset");

    // Randomized lock traffic with occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
      end else begin
        int hold;
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = pll_locked ? $urandom_range(1, 50) : $urandom_range(1, 4);
        for (int c = 0; c < hold; c++) tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
